tdc_echo_packer: RTL and testbench

TDC_ECHO_PACKER -- requirements
Module: tdc_echo_packer

---
 rtl/tdc_pkg.sv | 47 ++++
 rtl/tdc_rec_fifo.sv | 52 +++++
 rtl/tdc_echo_packer.sv | 150 +++++++++++++++
 tb/tb_tdc_echo_packer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared widths, record field positions and FSM encoding for the TDC echo packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

    localparam int TOF_W = 10;
    localparam int INT_W = 5;
    localparam int NUM_W = 2;
    localparam int SEQ_W = 4;
    localparam int REC_W = 32;

    // LSB position of each record field
    localparam int SECOND_TOF_LSB = 0;
    localparam int BEST_TOF_LSB   = 10;
    localparam int BEST_INT_LSB   = 20;
    localparam int OVF_LSB        = 25;
    localparam int NUM_LSB        = 26;
    localparam int SEQ_LSB        = 28;

    localparam logic [NUM_W-1:0] NUM_MAX = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_e;

    function automatic logic [REC_W-1:0] pack_rec(
        input logic [SEQ_W-1:0] seq,
        input logic [NUM_W-1:0] num,
        input logic             ovf,
        input logic [INT_W-1:0] best_int,
        input logic [TOF_W-1:0] best_tof,
        input logic [TOF_W-1:0] second_tof
    );
        logic [REC_W-1:0] r;
        r = '0;
        r[SEQ_LSB        +: SEQ_W] = seq;
        r[NUM_LSB        +: NUM_W] = num;
        r[OVF_LSB]                 = ovf;
        r[BEST_INT_LSB   +: INT_W] = best_int;
        r[BEST_TOF_LSB   +: TOF_W] = best_tof;
        r[SECOND_TOF_LSB +: TOF_W] = second_tof;
        return r;
    endfunction

endpackage

// File: rtl/tdc_rec_fifo.sv
// First-word-fall-through record FIFO; head is zero while empty.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
module tdc_rec_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty when the indices match
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_dat;
        end
    end

    // Read/write pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/tdc_echo_packer.sv
// Packs up to three TDC echoes per frame into one 32-bit record (best/second by intensity).
// Latency: record reaches out_valid one cycle after EMIT pushes it (two cycles after the closing beat).
// Backpressure: in_ready drops in EMIT and stays low while the record FIFO is full.
module tdc_echo_packer
    import tdc_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit EMPTY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TOF_W-1:0] in_data,
    input  logic [INT_W-1:0] in_int,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame_tick,
    output logic [REC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       drop_cnt
);

    state_e           state_q;
    logic [NUM_W-1:0] num_q, num_d;
    logic             ovf_q, ovf_d;
    logic [INT_W-1:0] best_int_q, best_int_d;
    logic [TOF_W-1:0] best_tof_q, best_tof_d;
    logic [INT_W-1:0] sec_int_q, sec_int_d;
    logic [TOF_W-1:0] sec_tof_q, sec_tof_d;
    logic [SEQ_W-1:0] seq_q;
    logic [7:0]       drop_q;

    logic             beat_acc;
    logic             drop_ev;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] rec;

    assign in_ready  = (state_q != S_EMIT);
    assign beat_acc  = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    // A full FIFO still takes the record when the head leaves the same cycle
    assign fifo_push = (state_q == S_EMIT) && (!fifo_full || out_ready);
    // Lost frame: tick while a record is still waiting, or an empty frame that is not reported
    assign drop_ev   = frame_tick && ((state_q == S_EMIT) ||
                       ((state_q == S_IDLE) && !beat_acc && !EMPTY_EN));
    assign drop_cnt  = drop_q;
    assign rec       = pack_rec(seq_q, num_q, ovf_q, best_int_q, best_tof_q, sec_tof_q);

    // Frame statistics after applying the current beat; ties keep the earlier echo
    always_comb begin
        num_d      = num_q;
        ovf_d      = ovf_q;
        best_int_d = best_int_q;
        best_tof_d = best_tof_q;
        sec_int_d  = sec_int_q;
        sec_tof_d  = sec_tof_q;
        if (beat_acc) begin
            if (num_q == NUM_MAX) begin
                ovf_d = 1'b1;
            end else begin
                num_d = num_q + 2'd1;
                if (num_q == 2'd0) begin
                    best_int_d = in_int;
                    best_tof_d = in_data;
                end else if (in_int > best_int_q) begin
                    sec_int_d  = best_int_q;
                    sec_tof_d  = best_tof_q;
                    best_int_d = in_int;
                    best_tof_d = in_data;
                end else if ((num_q == 2'd1) || (in_int > sec_int_q)) begin
                    sec_int_d  = in_int;
                    sec_tof_d  = in_data;
                end
            end
        end
    end

    // Frame FSM, per-frame registers, sequence and drop counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            ovf_q      <= 1'b0;
            best_int_q <= '0;
            best_tof_q <= '0;
            sec_int_q  <= '0;
            sec_tof_q  <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
        end else begin
            if (drop_ev && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            case (state_q)
                S_IDLE, S_COLLECT: begin
                    num_q      <= num_d;
                    ovf_q      <= ovf_d;
                    best_int_q <= best_int_d;
                    best_tof_q <= best_tof_d;
                    sec_int_q  <= sec_int_d;
                    sec_tof_q  <= sec_tof_d;
                    if (beat_acc && in_last) begin
                        state_q <= S_EMIT;
                    end else if (frame_tick && ((state_q == S_COLLECT) || beat_acc)) begin
                        // Range ended before in_last: truncated frame
                        ovf_q   <= 1'b1;
                        state_q <= S_EMIT;
                    end else if (frame_tick && EMPTY_EN) begin
                        state_q <= S_EMIT;
                    end else if (beat_acc) begin
                        state_q <= S_COLLECT;
                    end
                end
                S_EMIT: begin
                    if (fifo_push) begin
                        state_q    <= S_IDLE;
                        num_q      <= '0;
                        ovf_q      <= 1'b0;
                        best_int_q <= '0;
                        best_tof_q <= '0;
                        sec_int_q  <= '0;
                        sec_tof_q  <= '0;
                        seq_q      <= seq_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    tdc_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (rec),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (out_data)
    );

endmodule

// File: tb/tb_tdc_echo_packer.sv
// Self-checking bench for tdc_echo_packer: directed scenarios plus randomized frames vs. a frame-level model.
// Latency: n/a.
// Backpressure: consumer out_ready forced low, high or randomized per scenario.
module tb_tdc_echo_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  in_data;
    logic [4:0]  in_int;
    logic        in_last;
    logic        in_valid;
    logic        frame_tick;
    logic        out_ready;
    logic        in_ready,  in_ready0;
    logic        out_valid, out_valid0;
    logic [31:0] out_data,  out_data0;
    logic [7:0]  drop_cnt,  drop_cnt0;

    int          checks   = 0;
    int          failures = 0;
    int          rdy_mode = 1;        // 0: out_ready low, 1: high, 2: random
    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    // Frame model: beats of the current frame and next expected sequence number
    logic [9:0]  fr_tof[8];
    logic [4:0]  fr_int[8];
    int          fr_n    = 0;
    int          exp_seq = 0;

    always #2 clk = ~clk;

    tdc_echo_packer #(.DEPTH(4), .EMPTY_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_int(in_int), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .frame_tick(frame_tick),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    tdc_echo_packer #(.DEPTH(4), .EMPTY_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_int(in_int), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready0), .frame_tick(frame_tick),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready), .drop_cnt(drop_cnt0)
    );

    // Consumer: choose out_ready for the coming edge, then log the record that edge pops
    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (rst_n && out_valid && out_ready) got.push_back(out_data);
    end

    // Record from the frame's beats: only the first three count; best = highest
    // intensity (earliest on ties), second = highest of the rest (earliest on ties)
    function automatic logic [31:0] model_rec(input bit trunc);
        int n;
        int bi;
        int si;
        logic [31:0] r;
        n  = (fr_n > 3) ? 3 : fr_n;
        bi = -1;
        si = -1;
        for (int i = 0; i < n; i++)
            if (bi < 0 || fr_int[i] > fr_int[bi]) bi = i;
        for (int i = 0; i < n; i++)
            if (i != bi && (si < 0 || fr_int[i] > fr_int[si])) si = i;
        r        = '0;
        r[31:28] = exp_seq[3:0];
        r[27:26] = n[1:0];
        r[25]    = (fr_n > 3) || trunc;
        if (bi >= 0) begin
            r[24:20] = fr_int[bi];
            r[19:10] = fr_tof[bi];
        end
        if (si >= 0) r[9:0] = fr_tof[si];
        return r;
    endfunction

    task automatic close_frame(input bit trunc);
        exp_q.push_back(model_rec(trunc));
        exp_seq = (exp_seq + 1) % 16;
        fr_n    = 0;
    endtask

    task automatic send_beat(input logic [9:0] tof, input logic [4:0] it, input bit last, input bit tick);
        int guard;
        guard = 0;
        @(negedge clk);
        in_data  = tof;
        in_int   = it;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            checks++; failures++;
            $display("FAIL beat_accept timeout in_ready=%0b required=1", in_ready);
        end
        frame_tick = tick;
        @(negedge clk);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        frame_tick = 1'b0;
        if (fr_n < 8) begin
            fr_tof[fr_n] = tof;
            fr_int[fr_n] = it;
        end
        fr_n++;
    endtask

    task automatic pulse_tick;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_recs(input string name);
        int guard;
        guard = 0;
        while (got.size() < exp_q.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            checks++; failures++;
            $display("FAIL %s record_timeout got=%0d required=%0d", name, got.size(), exp_q.size());
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        exp_q.delete();
        fr_n    = 0;
        exp_seq = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (drop_cnt !== 8'h0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
        checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL rst_in_ready0 got=%b exp=1", in_ready0); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] g;
        logic [31:0] e;
        rdy_mode = 1;
        send_beat(10'd100, 5'd3, 1'b0, 1'b0);
        send_beat(10'd200, 5'd9, 1'b0, 1'b0);
        send_beat(10'd300, 5'd9, 1'b1, 1'b0);
        close_frame(1'b0);
        wait_recs("basic");
        e = exp_q.pop_front();
        g = (got.size() > 0) ? got.pop_front() : 32'hxxxx_xxxx;
        checks++; if (g !== e) begin failures++; $display("FAIL basic_model got=%h exp=%h", g, e); end
        checks++; if (g !== {4'd0, 2'd3, 1'b0, 5'd9, 10'd200, 10'd300}) begin
            failures++; $display("FAIL basic_fields got=%h exp=%h", g, {4'd0, 2'd3, 1'b0, 5'd9, 10'd200, 10'd300});
        end
    endtask

    task automatic test_empty;
        logic [31:0] g;
        logic [31:0] e;
        do_reset();
        rdy_mode = 1;
        pulse_tick();
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL empty_off_valid got=%b exp=0", out_valid0); end
        checks++; if (out_data0 !== 32'h0) begin failures++; $display("FAIL empty_off_data got=%h exp=0", out_data0); end
        checks++; if (drop_cnt0 !== 8'd1) begin failures++; $display("FAIL empty_off_drop got=%0d exp=1", drop_cnt0); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL empty_on_drop got=%0d exp=0", drop_cnt); end
        close_frame(1'b0);
        send_beat(10'd55, 5'd4, 1'b1, 1'b0);
        close_frame(1'b0);
        wait_recs("empty");
        g = (got.size() > 0) ? got[0] : 32'hxxxx_xxxx;
        checks++; if (g !== 32'h0000_0000) begin failures++; $display("FAIL empty_rec got=%h exp=00000000", g); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got.size() > 0) ? got.pop_front() : 32'hxxxx_xxxx;
            checks++; if (g !== e) begin failures++; $display("FAIL empty_seq got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] g;
        logic [31:0] e;
        send_beat(10'd10, 5'd2,  1'b0, 1'b0);
        send_beat(10'd20, 5'd6,  1'b0, 1'b0);
        send_beat(10'd30, 5'd4,  1'b0, 1'b0);
        send_beat(10'd40, 5'd31, 1'b1, 1'b0);
        close_frame(1'b0);
        wait_recs("ovf");
        e = exp_q.pop_front();
        g = (got.size() > 0) ? got.pop_front() : 32'hxxxx_xxxx;
        checks++; if (g !== e) begin failures++; $display("FAIL ovf_rec got=%h exp=%h", g, e); end
        checks++; if (g[27:20] !== {2'd3, 1'b1, 5'd6}) begin
            failures++; $display("FAIL ovf_num_flag got=%h exp=%h", g[27:20], {2'd3, 1'b1, 5'd6});
        end
    endtask

    task automatic test_truncate;
        logic [31:0] g;
        logic [31:0] e;
        send_beat(10'd7, 5'd1, 1'b0, 1'b0);
        send_beat(10'd8, 5'd2, 1'b0, 1'b0);
        pulse_tick();
        close_frame(1'b1);
        send_beat(10'd9, 5'd3, 1'b1, 1'b1);     // tick on the same cycle as in_last
        close_frame(1'b0);
        wait_recs("trunc");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got.size() > 0) ? got.pop_front() : 32'hxxxx_xxxx;
            checks++; if (g !== e) begin failures++; $display("FAIL trunc_rec got=%h exp=%h", g, e); end
        end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL trunc_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_stall;
        logic [31:0] g;
        logic [31:0] e;
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) send_beat(10'(100 + i), 5'(i + 1), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            fr_n = 0;
            fr_tof[0] = 10'(100 + i);
            fr_int[0] = 5'(i + 1);
            fr_n = 1;
            close_frame(1'b0);
        end
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL stall_head got=%h exp=%h", out_data, exp_q[0]); end
        pulse_tick();
        checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL stall_drop got=%0d exp=1", drop_cnt); end
        checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL stall_hold got=%h exp=%h", out_data, exp_q[0]); end
        checks++; if (got.size() != 0) begin failures++; $display("FAIL stall_nopop got=%0d exp=0", got.size()); end
        rdy_mode = 1;
        wait_recs("stall");
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            g = (got.size() > 0) ? got.pop_front() : 32'hxxxx_xxxx;
            checks++; if (g !== e) begin failures++; $display("FAIL stall_drain%0d got=%h exp=%h", i, g, e); end
        end
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] g;
        logic [31:0] e;
        rdy_mode = 0;
        send_beat(10'd1, 5'd1, 1'b1, 1'b0);     // complete frame left sitting in the FIFO
        send_beat(10'd500, 5'd20, 1'b0, 1'b0);
        send_beat(10'd600, 5'd25, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rmid_drop got=%0d exp=0", drop_cnt); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        exp_q.delete();
        fr_n    = 0;
        exp_seq = 0;
        rdy_mode = 1;
        send_beat(10'd700, 5'd2, 1'b1, 1'b0);
        close_frame(1'b0);
        wait_recs("rmid");
        e = exp_q.pop_front();
        g = (got.size() > 0) ? got.pop_front() : 32'hxxxx_xxxx;
        checks++; if (g !== e) begin failures++; $display("FAIL rmid_rec got=%h exp=%h", g, e); end
        checks++; if (g !== {4'd0, 2'd1, 1'b0, 5'd2, 10'd700, 10'd0}) begin
            failures++; $display("FAIL rmid_fields got=%h exp=%h", g, {4'd0, 2'd1, 1'b0, 5'd2, 10'd700, 10'd0});
        end
    endtask

    task automatic test_random;
        logic [31:0] g;
        logic [31:0] e;
        int nb;
        int k;
        do_reset();
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                send_beat(10'($urandom_range(0, 1023)), 5'($urandom_range(0, 7)), (b == nb - 1), 1'b0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            close_frame(1'b0);
        end
        rdy_mode = 1;
        wait_recs("rand");
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got.size() > 0) ? got.pop_front() : 32'hxxxx_xxxx;
            checks++; if (g !== e) begin failures++; $display("FAIL rand_rec%0d got=%h exp=%h", k, g, e); end
            k++;
        end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rand_drop got=%0d exp=0", drop_cnt); end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_int     = '0;
        in_last    = 1'b0;
        in_valid   = 1'b0;
        frame_tick = 1'b0;
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_truncate();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
